// File: rtl/ctrl_pipe_hazard.sv
// rtl/ctrl_pipe_hazard.sv - pipelined MIPS control carrier with load-use stall, flush and forwarding
//
// Carries the decoded control bundle from ID through ID/EX, EX/MEM and MEM/WB,
// picks each instruction's destination register, inserts a one-cycle bubble on
// a load-use hazard, flushes IF/ID on jumps and taken branches, and drives the
// EX-stage forwarding selects.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   id_valid, id_ctrl          ID instruction valid and decoded control bundle
//                              {RegDst[13:12],Jump,Branch,MemRead,MemReg[8:7],
//                               AluSrc,RegWrite,MemWrite,AluOp[3:0]}
//   id_rs, id_rt, id_rd        ID register fields
//   ex_br_taken                branch condition in EX (only meaningful with ex_branch)
//   ex_alu_op, ex_alu_src      EX ALU controls
//   ex_branch, ex_dst          EX branch flag and destination register
//   fwd_a, fwd_b               forward selects: 10=EX/MEM, 01=MEM/WB, 00=regfile
//   mem_read, mem_write        MEM-stage data-memory controls
//   wb_reg_write, wb_mem_reg   WB write enable and source (0=ALU, 1=mem, 2=PC+4)
//   wb_dst                     WB destination register
//   pc_we, ifid_we             PC and IF/ID write enables (0 = stall)
//   ifid_flush                 IF/ID loads a bubble
//   stall_cnt, flush_cnt       saturating event counters

module ctrl_pipe_hazard #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [13:0]      id_ctrl,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_br_taken,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic [REG_W-1:0] ex_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_reg_write,
  output logic [1:0]       wb_mem_reg,
  output logic [REG_W-1:0] wb_dst,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // ID-side field decode
  logic [1:0] id_reg_dst;
  logic       id_jump;
  logic       id_branch;
  logic       id_mem_read;
  logic [1:0] id_mem_reg;
  logic       id_alu_src;
  logic       id_reg_write;
  logic       id_mem_write;
  logic [3:0] id_alu_op;

  assign id_reg_dst   = id_ctrl[13:12];
  assign id_jump      = id_ctrl[11];
  assign id_branch    = id_ctrl[10];
  assign id_mem_read  = id_ctrl[9];
  assign id_mem_reg   = id_ctrl[8:7];
  assign id_alu_src   = id_ctrl[6];
  assign id_reg_write = id_ctrl[5];
  assign id_mem_write = id_ctrl[4];
  assign id_alu_op    = id_ctrl[3:0];

  // ID/EX state beyond the ex_* outputs
  logic             ex_valid;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic [1:0]       ex_mem_reg;
  logic             ex_reg_write;

  // EX/MEM state beyond the mem_* outputs
  logic [REG_W-1:0] mem_dst;
  logic             mem_reg_write;
  logic [1:0]       mem_mem_reg;

  logic [REG_W-1:0] id_dst;
  logic             id_reg_write_eff;
  logic             load_use;
  logic             br_flush;
  logic             stall;
  logic             idex_bubble;

  always_comb begin
    id_dst = '0;
    case (id_reg_dst)
      2'd0:    id_dst = id_rt;
      2'd1:    id_dst = id_rd;
      2'd2:    id_dst = REG_W'(31);
      default: id_dst = '0;
    endcase
  end

  // Writes to $0 are dropped here so forwarding never matches register 0.
  assign id_reg_write_eff = id_reg_write & (id_dst != '0);

  // rt only counts as a source when it is actually read: R-type (AluSrc=0)
  // or a store, which reads rt as the data to write.
  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_dst != '0) &
                    ((ex_dst == id_rs) |
                     ((ex_dst == id_rt) & (~id_alu_src | id_mem_write)));

  assign br_flush = ex_valid & ex_branch & ex_br_taken;

  // A taken branch discards the stalled ID instruction, so the fetch must
  // move on to the target rather than hold.
  assign stall       = load_use & ~br_flush;
  assign idex_bubble = ~id_valid | load_use | br_flush;

  assign pc_we      = ~stall;
  assign ifid_we    = ~stall;
  assign ifid_flush = br_flush | (id_valid & id_jump);

  // ID/EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      ex_branch    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_mem_reg   <= '0;
      ex_reg_write <= 1'b0;
    end else if (idex_bubble) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      ex_branch    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_mem_reg   <= '0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_dst       <= id_dst;
      ex_alu_op    <= id_alu_op;
      ex_alu_src   <= id_alu_src;
      ex_branch    <= id_branch;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_mem_reg   <= id_mem_reg;
      ex_reg_write <= id_reg_write_eff;
    end
  end

  // EX/MEM and MEM/WB always advance; bubbles arrive with zeroed controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dst       <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_reg   <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      wb_dst        <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_reg    <= '0;
    end else begin
      mem_dst       <= ex_dst;
      mem_reg_write <= ex_reg_write;
      mem_mem_reg   <= ex_mem_reg;
      mem_read      <= ex_mem_read;
      mem_write     <= ex_mem_write;
      wb_dst        <= mem_dst;
      wb_reg_write  <= mem_reg_write;
      wb_mem_reg    <= mem_mem_reg;
    end
  end

  // The younger producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    if (mem_reg_write && (mem_dst == ex_rs))
      fwd_a = 2'b10;
    else if (wb_reg_write && (wb_dst == ex_rs))
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (mem_reg_write && (mem_dst == ex_rt))
      fwd_b = 2'b10;
    else if (wb_reg_write && (wb_dst == ex_rt))
      fwd_b = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb/tb_ctrl_pipe_hazard.sv - self-checking bench for ctrl_pipe_hazard
module tb_ctrl_pipe_hazard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [13:0] id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_br_taken;

  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_branch;
  logic [4:0]  ex_dst;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_read, mem_write, wb_reg_write;
  logic [1:0]  wb_mem_reg;
  logic [4:0]  wb_dst;
  logic        pc_we, ifid_we, ifid_flush;
  logic [15:0] stall_cnt, flush_cnt;

  logic [3:0]  s_ex_alu_op;
  logic        s_ex_alu_src, s_ex_branch;
  logic [4:0]  s_ex_dst;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_mem_read, s_mem_write, s_wb_reg_write;
  logic [1:0]  s_wb_mem_reg;
  logic [4:0]  s_wb_dst;
  logic        s_pc_we, s_ifid_we, s_ifid_flush;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  ctrl_pipe_hazard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_dst(ex_dst), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_read(mem_read),
    .mem_write(mem_write), .wb_reg_write(wb_reg_write), .wb_mem_reg(wb_mem_reg),
    .wb_dst(wb_dst), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy so saturation of both counters is reached quickly.
  ctrl_pipe_hazard #(.REG_W(5), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .ex_alu_op(s_ex_alu_op), .ex_alu_src(s_ex_alu_src), .ex_branch(s_ex_branch),
    .ex_dst(s_ex_dst), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .wb_reg_write(s_wb_reg_write), .wb_mem_reg(s_wb_mem_reg),
    .wb_dst(s_wb_dst), .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Reference model: one record per in-flight instruction.
  typedef struct packed {
    logic       valid;
    logic [4:0] rs, rt, dst;
    logic       reg_write, mem_read, mem_write;
    logic [1:0] mem_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       branch;
  } rec_t;

  rec_t pipe [3];   // [0]=EX, [1]=MEM, [2]=WB
  int   stall_n, flush_n;
  int   tests = 0;
  int   fails = 0;

  logic [13:0] c_lw, c_add, c_sub, c_brld, c_jal, c_addi, c_j;

  function automatic logic [13:0] mk(logic [1:0] rsel, logic j, logic br, logic mrd,
                                     logic [1:0] mreg, logic asrc, logic rw, logic mwr,
                                     logic [3:0] op);
    return {rsel, j, br, mrd, mreg, asrc, rw, mwr, op};
  endfunction

  function automatic rec_t decode(logic [13:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    rec_t r;
    r = '0;
    r.valid = 1'b1;
    r.rs = rs;
    r.rt = rt;
    case (c[13:12])
      2'd0: r.dst = rt;
      2'd1: r.dst = rd;
      2'd2: r.dst = 5'd31;
      default: r.dst = 5'd0;
    endcase
    r.reg_write = c[5] && (r.dst != 5'd0);
    r.mem_read  = c[9];
    r.mem_write = c[4];
    r.mem_reg   = c[8:7];
    r.alu_src   = c[6];
    r.alu_op    = c[3:0];
    r.branch    = c[10];
    return r;
  endfunction

  function automatic logic [1:0] fwd_of(logic [4:0] s, rec_t m, rec_t w);
    if (m.reg_write && m.dst == s) return 2'b10;
    if (w.reg_write && w.dst == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(int n, int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    stall_n = 0;
    flush_n = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the current inputs, then
  // advance the model by one clock.
  task automatic check_and_advance();
    rec_t ex, mm, wb, nxt;
    logic ld_use, taken, stall, flush;
    logic [1:0] fa, fb;
    logic [27:0] exp_vec, s_vec;
    ex = pipe[0];
    mm = pipe[1];
    wb = pipe[2];
    ld_use = id_valid && ex.valid && ex.mem_read && (ex.dst != 0) &&
             ((ex.dst == id_rs) || ((ex.dst == id_rt) && (!id_ctrl[6] || id_ctrl[4])));
    taken = ex.valid && ex.branch && ex_br_taken;
    stall = ld_use && !taken;
    flush = taken || (id_valid && id_ctrl[11]);
    fa = fwd_of(ex.rs, mm, wb);
    fb = fwd_of(ex.rt, mm, wb);

    chk("ex_alu_op",    32'(ex_alu_op),    32'(ex.alu_op));
    chk("ex_alu_src",   32'(ex_alu_src),   32'(ex.alu_src));
    chk("ex_branch",    32'(ex_branch),    32'(ex.branch));
    chk("ex_dst",       32'(ex_dst),       32'(ex.dst));
    chk("fwd_a",        32'(fwd_a),        32'(fa));
    chk("fwd_b",        32'(fwd_b),        32'(fb));
    chk("mem_read",     32'(mem_read),     32'(mm.mem_read));
    chk("mem_write",    32'(mem_write),    32'(mm.mem_write));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(wb.reg_write));
    chk("wb_mem_reg",   32'(wb_mem_reg),   32'(wb.mem_reg));
    chk("wb_dst",       32'(wb_dst),       32'(wb.dst));
    chk("pc_we",        32'(pc_we),        32'(!stall));
    chk("ifid_we",      32'(ifid_we),      32'(!stall));
    chk("ifid_flush",   32'(ifid_flush),   32'(flush));
    chk("stall_cnt",    32'(stall_cnt),    32'(sat(stall_n, 16)));
    chk("flush_cnt",    32'(flush_cnt),    32'(sat(flush_n, 16)));
    chk("s_stall_cnt",  32'(s_stall_cnt),  32'(sat(stall_n, 3)));
    chk("s_flush_cnt",  32'(s_flush_cnt),  32'(sat(flush_n, 3)));

    exp_vec = {ex.alu_op, ex.alu_src, ex.branch, ex.dst, fa, fb, mm.mem_read, mm.mem_write,
               wb.reg_write, wb.mem_reg, wb.dst, !stall, !stall, flush};
    s_vec = {s_ex_alu_op, s_ex_alu_src, s_ex_branch, s_ex_dst, s_fwd_a, s_fwd_b, s_mem_read,
             s_mem_write, s_wb_reg_write, s_wb_mem_reg, s_wb_dst, s_pc_we, s_ifid_we, s_ifid_flush};
    chk("s_outputs", 32'(s_vec), 32'(exp_vec));

    if (!id_valid || ld_use || taken) nxt = '0;
    else nxt = decode(id_ctrl, id_rs, id_rt, id_rd);
    pipe[2] = mm;
    pipe[1] = ex;
    pipe[0] = nxt;
    if (stall) stall_n++;
    if (flush) flush_n++;
  endtask

  task automatic step(input logic v, input logic [13:0] c, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic bt);
    @(negedge clk);
    id_valid = v;
    id_ctrl = c;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    ex_br_taken = bt;
    #1;
    check_and_advance();
  endtask

  initial begin
    c_lw   = mk(2'd0, 0, 0, 1, 2'd1, 1, 1, 0, 4'd0);
    c_add  = mk(2'd1, 0, 0, 0, 2'd0, 0, 1, 0, 4'd2);
    c_sub  = mk(2'd1, 0, 0, 0, 2'd0, 0, 1, 0, 4'd6);
    c_brld = mk(2'd0, 0, 1, 1, 2'd0, 0, 1, 0, 4'd6);
    c_jal  = mk(2'd2, 1, 0, 0, 2'd2, 0, 1, 0, 4'd0);
    c_addi = mk(2'd0, 0, 0, 0, 2'd0, 1, 1, 0, 4'd2);
    c_j    = mk(2'd0, 1, 0, 0, 2'd0, 0, 0, 0, 4'd0);

    rst_n = 1'b0;
    id_valid = 1'b0;
    id_ctrl = '0;
    id_rs = '0;
    id_rt = '0;
    id_rd = '0;
    ex_br_taken = 1'b0;
    model_reset();
    #12;
    chk("rst_pc_we",      32'(pc_we),      32'd1);
    chk("rst_ifid_flush", 32'(ifid_flush), 32'd0);
    chk("rst_fwd",        32'({fwd_a, fwd_b}), 32'd0);
    chk("rst_stall_cnt",  32'(stall_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw $8 then add $9,$8,$2
    step(1, c_lw, 5'd1, 5'd8, 5'd0, 0);
    step(1, c_add, 5'd8, 5'd2, 5'd9, 0);
    chk("t1_pc_we_stall", 32'(pc_we), 32'd0);
    step(1, c_add, 5'd8, 5'd2, 5'd9, 0);
    chk("t1_bubble_dst", 32'(ex_dst), 32'd0);
    chk("t1_stall_cnt", 32'(stall_cnt), 32'd1);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);
    chk("t1_fwd_a", 32'(fwd_a), 32'd1);
    chk("t1_ex_dst", 32'(ex_dst), 32'd9);

    // add $3,$1,$2 then sub $4,$3,$3
    step(1, c_add, 5'd1, 5'd2, 5'd3, 0);
    step(1, c_sub, 5'd3, 5'd3, 5'd4, 0);
    chk("t2_no_stall", 32'(pc_we), 32'd1);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);
    chk("t2_fwd", 32'({fwd_a, fwd_b}), 32'b1010);

    // branch (also loading $5) taken in EX while ID would load-use stall
    step(1, c_brld, 5'd1, 5'd5, 5'd0, 0);
    step(1, c_add, 5'd5, 5'd2, 5'd6, 1);
    chk("t3_flush", 32'(ifid_flush), 32'd1);
    chk("t3_pc_we", 32'({pc_we, ifid_we}), 32'b11);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);
    chk("t3_bubble", 32'({ex_dst, ex_branch}), 32'd0);
    chk("t3_flush_cnt", 32'(flush_cnt), 32'd1);

    // jal
    step(1, c_jal, 5'd0, 5'd0, 5'd0, 0);
    chk("t4_flush", 32'(ifid_flush), 32'd1);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);
    chk("t4_flush_off", 32'(ifid_flush), 32'd0);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);
    chk("t4_wb_early", 32'(wb_reg_write), 32'd0);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);
    chk("t4_wb", 32'({wb_dst, wb_reg_write, wb_mem_reg}), 32'({5'd31, 1'b1, 2'd2}));

    // addi with rt=0, then a consumer of $0
    step(1, c_addi, 5'd1, 5'd0, 5'd0, 0);
    step(1, c_add, 5'd0, 5'd0, 5'd5, 0);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);
    chk("t5_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);
    chk("t5_wb_rw", 32'(wb_reg_write), 32'd0);

    // randomized traffic with a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      logic [13:0] c;
      c = 14'($urandom);
      c[11] = ($urandom_range(0, 7) == 0);
      c[10] = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 9) != 0), c, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom));
    end

    // flush counter saturation at full width
    @(negedge clk);
    id_valid = 1'b1;
    id_ctrl = c_j;
    ex_br_taken = 1'b0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("sat_flush_cnt", 32'(flush_cnt), 32'hFFFF);
    chk("sat_stall_hold", 32'(stall_cnt), 32'(sat(stall_n, 16)));
    chk("sat_s_flush_cnt", 32'(s_flush_cnt), 32'd7);

    // asynchronous reset between clock edges
    id_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_comb", 32'({pc_we, ifid_we, ifid_flush, fwd_a, fwd_b}), 32'b1100000);
    chk("arst_stages", 32'({ex_dst, ex_branch, mem_read, mem_write, wb_reg_write, wb_dst}), 32'd0);
    chk("arst_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
    chk("arst_s_cnt", 32'({s_stall_cnt, s_flush_cnt}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, c_lw, 5'd1, 5'd7, 5'd0, 0);
    step(1, c_add, 5'd7, 5'd7, 5'd2, 0);
    step(0, '0, 5'd0, 5'd0, 5'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
